// File: rtl/fft_input_bitrev_loader_if.sv
// rtl/fft_input_bitrev_loader_if.sv - serial word input and complex sample output bundle for the FFT loader
interface fft_input_bitrev_loader_if #(
    parameter int DATA_W = 17
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] out_r;
    logic [DATA_W-1:0] out_i;
    logic              out_valid;
    logic              out_start;
    logic              out_last;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_r, out_i, out_valid, out_start, out_last
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_r, out_i, out_valid, out_start, out_last
    );
endinterface

// File: rtl/fft_input_bitrev_loader.sv
// rtl/fft_input_bitrev_loader.sv - buffers a real-then-imag frame and replays it in bit-reversed order
// Optional FFT_LOADER_PINGPONG_EN: two banks so loading overlaps emission.
module fft_input_bitrev_loader #(
    parameter int DATA_W = 17,
    parameter int N_LOG2 = 5
) (
    input logic                      clk,
    input logic                      rst_n,
    fft_input_bitrev_loader_if.slave bus
);
    localparam int N = 1 << N_LOG2;
    localparam logic [1:0] LOAD_RE = 2'd0;
    localparam logic [1:0] LOAD_IM = 2'd1;

`ifdef FFT_LOADER_PINGPONG_EN
    localparam int AW = N_LOG2 + 1;
`else
    localparam int AW = N_LOG2;
`endif

    logic [1:0]        state;
    logic [N_LOG2-1:0] wcnt;
    logic [N_LOG2-1:0] kcnt;
    logic [N_LOG2-1:0] rev_k;
    logic              emitting;
    logic              accept;
    logic              emit_last;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] re_mem [1 << AW];
    logic [DATA_W-1:0] im_mem [1 << AW];

    assign accept    = bus.in_valid && bus.in_ready;
    assign emit_last = emitting && (kcnt == '1);

    always_comb begin
        rev_k = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            rev_k[i] = kcnt[N_LOG2-1-i];
        end
    end

`ifdef FFT_LOADER_PINGPONG_EN
    logic       wr_bank;
    logic       rd_bank;
    logic       nxt_rd;
    logic       load_done;
    logic [1:0] full;
    logic [1:0] full_n;

    assign load_done    = accept && (state == LOAD_IM) && (wcnt == '1);
    assign bus.in_ready = ~(full[0] & full[1]);
    assign wr_addr      = {wr_bank, wcnt};
    assign rd_addr      = {rd_bank, rev_k};

    // A bank filled on this edge is visible to the emitter on the same edge,
    // so k=0 lands on the cycle right after the 64th word.
    always_comb begin
        full_n = full;
        if (load_done) full_n[wr_bank] = 1'b1;
        if (emit_last) full_n[rd_bank] = 1'b0;
        nxt_rd = rd_bank ^ emit_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD_RE;
            wcnt     <= '0;
            kcnt     <= '0;
            emitting <= 1'b0;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
        end else begin
            if (accept) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == '1) state <= (state == LOAD_RE) ? LOAD_IM : LOAD_RE;
            end
            if (load_done) wr_bank <= ~wr_bank;
            full     <= full_n;
            rd_bank  <= nxt_rd;
            emitting <= (emitting && !emit_last) || full_n[nxt_rd];
            kcnt     <= emitting ? kcnt + 1'b1 : '0;
        end
    end
`else
    localparam logic [1:0] EMIT = 2'd2;

    assign emitting     = (state == EMIT);
    assign bus.in_ready = !emitting;
    assign wr_addr      = wcnt;
    assign rd_addr      = rev_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_RE;
            wcnt  <= '0;
            kcnt  <= '0;
        end else begin
            case (state)
                LOAD_RE: if (accept) begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == '1) state <= LOAD_IM;
                end
                LOAD_IM: if (accept) begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == '1) begin
                        state <= EMIT;
                        kcnt  <= '0;
                    end
                end
                EMIT: begin
                    kcnt <= kcnt + 1'b1;
                    if (kcnt == '1) state <= LOAD_RE;
                end
                default: state <= LOAD_RE;
            endcase
        end
    end
`endif

    // Buffer has no reset; contents are only read after a full frame is written.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (state == LOAD_RE) re_mem[wr_addr] <= bus.in_data;
            else                  im_mem[wr_addr] <= bus.in_data;
        end
    end

    assign bus.out_valid = emitting;
    assign bus.out_r     = emitting ? re_mem[rd_addr] : '0;
    assign bus.out_i     = emitting ? im_mem[rd_addr] : '0;
    assign bus.out_start = emitting && (kcnt == '0);
    assign bus.out_last  = emit_last;
endmodule

// File: tb/tb_fft_input_bitrev_loader.sv
// tb/tb_fft_input_bitrev_loader.sv - directed self-checking bench for fft_input_bitrev_loader
module tb_fft_input_bitrev_loader;
    localparam int DATA_W = 17;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n_start;
    logic [DATA_W-1:0] exp_re [32];
    logic [DATA_W-1:0] exp_im [32];
    logic [DATA_W-1:0] cap_r [$];
    logic [DATA_W-1:0] cap_i [$];

    always #5 clk = ~clk;

    fft_input_bitrev_loader_if #(.DATA_W(DATA_W)) bus ();

    fft_input_bitrev_loader #(.DATA_W(DATA_W), .N_LOG2(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bitrev5(input int k);
        int r = 0;
        for (int i = 0; i < 5; i++) if (k[i]) r = r | (1 << (4 - i));
        return r;
    endfunction

    task automatic set_ramp(input int rb, input int ib);
        for (int w = 0; w < 32; w++) begin
            exp_re[w] = DATA_W'(rb + w);
            exp_im[w] = DATA_W'(ib + w);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds exp_re then exp_im; captures any emitted samples seen meanwhile.
    task automatic load_frame(input int nwords, input bit gap, input bit chk_idle);
        int w = 0;
        int cyc = 0;
        bit acc;
        while (w < nwords && cyc < 400) begin
            if (bus.out_valid) begin
                cap_r.push_back(bus.out_r);
                cap_i.push_back(bus.out_i);
                if (bus.out_start) n_start++;
            end
            if (chk_idle) chk("load_idle_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("load_ready", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = gap ? (cyc[0] == 1'b0) : 1'b1;
            bus.in_data  = (w < 32) ? exp_re[w] : exp_im[w-32];
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) w++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("load_count", w, nwords);
    endtask

    task automatic check_emit(input bit junk);
        int a;
        cap_r.delete();
        cap_i.delete();
        for (int k = 0; k < 32; k++) begin
            a = bitrev5(k);
            cap_r.push_back(bus.out_r);
            cap_i.push_back(bus.out_i);
            chk("emit_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("emit_r", {15'd0, bus.out_r}, {15'd0, exp_re[a]});
            chk("emit_i", {15'd0, bus.out_i}, {15'd0, exp_im[a]});
            chk("emit_start", {31'd0, bus.out_start}, (k == 0) ? 32'd1 : 32'd0);
            chk("emit_last", {31'd0, bus.out_last}, (k == 31) ? 32'd1 : 32'd0);
            if (junk) begin
                bus.in_valid = 1'b1;
                bus.in_data  = '1;
                chk("emit_ready_low", {31'd0, bus.in_ready}, 32'd0);
            end
            step();
        end
        bus.in_valid = 1'b0;
        chk("post_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post_r_zero", {15'd0, bus.out_r}, 32'd0);
        chk("post_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_start"}, {31'd0, bus.out_start}, 32'd0);
        chk({tag, "_last"}, {31'd0, bus.out_last}, 32'd0);
        chk({tag, "_r"}, {15'd0, bus.out_r}, 32'd0);
        chk({tag, "_i"}, {15'd0, bus.out_i}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        n_start      = 0;
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Scenario 1: ramp frame, in_valid held high; junk offered during emit
        set_ramp(0, 100);
        load_frame(64, 1'b0, 1'b1);
`ifdef FFT_LOADER_PINGPONG_EN
        check_emit(1'b0);
`else
        check_emit(1'b1);
`endif
        chk("s1_k0_r", cap_r[0], 32'd0);
        chk("s1_k0_i", cap_i[0], 32'd100);
        chk("s1_k1_r", cap_r[1], 32'd16);
        chk("s1_k1_i", cap_i[1], 32'd116);
        chk("s1_k3_r", cap_r[3], 32'd24);
        chk("s1_k3_i", cap_i[3], 32'd124);
        chk("s1_k31_r", cap_r[31], 32'd31);
        chk("s1_k31_i", cap_i[31], 32'd131);

        // Scenario 2: same frame with in_valid every other cycle
        load_frame(64, 1'b1, 1'b1);
        check_emit(1'b0);
        chk("s2_k1_r", cap_r[1], 32'd16);
        chk("s2_k2_i", cap_i[2], 32'd108);

        // Scenario 4: reset after 40 words, then a full clean frame
        set_ramp(500, 600);
        load_frame(40, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        step();
        chk_reset_outputs("midreset_held");
        rst_n = 1'b1;
        step();
        set_ramp(0, 100);
        load_frame(64, 1'b0, 1'b1);
        check_emit(1'b0);
        chk("s4_k1_r", cap_r[1], 32'd16);
        chk("s4_k4_i", cap_i[4], 32'd104);

        // Scenario 6: sign/bit-exact corner values at index 16
        set_ramp(0, 100);
        exp_re[16] = 17'h10000;
        exp_im[16] = 17'h1FFFF;
        load_frame(64, 1'b0, 1'b1);
        check_emit(1'b0);
        chk("s6_k1_r", cap_r[1], 32'h10000);
        chk("s6_k1_i", cap_i[1], 32'h1FFFF);

`ifdef FFT_LOADER_PINGPONG_EN
        // Scenario 5: back-to-back frames; frame 2 loads while frame 1 drains
        set_ramp(0, 100);
        load_frame(64, 1'b0, 1'b1);
        cap_r.delete();
        cap_i.delete();
        n_start = 0;
        set_ramp(200, 300);
        load_frame(64, 1'b0, 1'b0);
        chk("s5_f1_count", cap_r.size(), 32'd32);
        chk("s5_f1_starts", n_start, 32'd1);
        chk("s5_f1_k1_r", cap_r[1], 32'd16);
        chk("s5_f1_k31_i", cap_i[31], 32'd131);
        check_emit(1'b0);
        chk("s5_f2_k1_r", cap_r[1], 32'd216);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
